// File: rtl/onc_16_dmem.sv
// Data-memory responder for the onc_16 CPU: synchronous word RAM plus an I/O window
// holding a byte TX FIFO, a status register and a free-running cycle counter.
module onc_16_dmem #(
  parameter int                DATA_W  = 16,
  parameter int                RAM_AW  = 12,
  parameter int                FIFO_AW = 2,
  parameter logic [DATA_W-1:0] IO_BASE = 16'hFF00
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [DATA_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_dout,
  input  logic              dmem_we,
  output logic [DATA_W-1:0] dmem_din,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int RAM_WORDS = 1 << RAM_AW;
  localparam int DEPTH     = 1 << FIFO_AW;

  localparam logic [DATA_W-1:0] TXDATA_ADDR = IO_BASE;
  localparam logic [DATA_W-1:0] STATUS_ADDR = IO_BASE + DATA_W'(1);
  localparam logic [DATA_W-1:0] CYCLE_ADDR  = IO_BASE + DATA_W'(2);

  logic [DATA_W-1:0] ram [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;

  logic              ram_sel;
  logic              txdata_sel;
  logic              status_sel;
  logic              cycle_sel;

  logic [7:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]  count;
  logic              full;
  logic              empty;
  logic              ovf;

  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              ovf_clear;

  logic [DATA_W-1:0] cycle_cnt;
  logic [DATA_W-1:0] io_rdata;

  assign ram_idx    = dmem_addr[RAM_AW-1:0];
  assign ram_sel    = (dmem_addr[DATA_W-1:RAM_AW] == '0);
  assign txdata_sel = (dmem_addr == TXDATA_ADDR);
  assign status_sel = (dmem_addr == STATUS_ADDR);
  assign cycle_sel  = (dmem_addr == CYCLE_ADDR);

  assign full     = (count == DEPTH[FIFO_AW:0]);
  assign empty    = (count == '0);
  assign tx_valid = !empty;
  assign tx_data  = fifo_mem[rd_ptr];

  // A push into a full FIFO still succeeds when the head leaves on the same edge.
  assign pop       = tx_valid && tx_ready;
  assign push_req  = dmem_we && txdata_sel;
  assign push_ok   = push_req && (!full || pop);
  assign ovf_clear = dmem_we && status_sel && dmem_dout[3];

  always_comb begin
    io_rdata = '0;
    if (status_sel) begin
      io_rdata = {{(DATA_W-4){1'b0}}, ovf, tx_valid, empty, full};
    end else if (cycle_sel) begin
      io_rdata = cycle_cnt;
    end
  end

  // RAM has no reset so a store during reset still lands.
  always_ff @(posedge clock) begin
    if (dmem_we && ram_sel) begin
      ram[ram_idx] <= dmem_dout;
    end
  end

  // Read-first: the old word is captured even when a store hits the same address.
  always_ff @(posedge clock) begin
    if (rst) begin
      dmem_din <= '0;
    end else if (ram_sel) begin
      dmem_din <= ram[ram_idx];
    end else begin
      dmem_din <= io_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= dmem_dout[7:0];
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push_ok) begin
        ovf <= 1'b1;
      end else if (ovf_clear) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (dmem_we && cycle_sel) begin
      cycle_cnt <= dmem_dout;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_onc_16_dmem.sv
// Self-checking bench for onc_16_dmem: directed scenarios then random traffic,
// all checked against a queue/array reference model of the memory map.
module tb_onc_16_dmem;

  logic        clock;
  logic        rst;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_dout;
  logic        dmem_we;
  logic [15:0] dmem_din;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  onc_16_dmem dut (
    .clock     (clock),
    .rst       (rst),
    .dmem_addr (dmem_addr),
    .dmem_dout (dmem_dout),
    .dmem_we   (dmem_we),
    .dmem_din  (dmem_din),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  logic [15:0] ram_m [0:4095];
  bit          ram_known [0:4095];
  byte unsigned q_m [$];
  bit          ovf_m;
  logic [15:0] cnt_m;
  bit          model_ok;
  logic [15:0] last_din;

  int checks;
  int errors;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check pre-edge stream outputs, advance model, check load data.
  task automatic applyStimulus(input logic r, input logic [15:0] a, input logic [15:0] d,
                               input logic w, input logic rdy);
    logic [15:0] exp_din;
    bit          chk_din;
    bit          pop_now;
    rst       = r;
    dmem_addr = a;
    dmem_dout = d;
    dmem_we   = w;
    tx_ready  = rdy;
    if (model_ok) begin
      checkOutput("tx_valid", {15'b0, tx_valid}, {15'b0, q_m.size() != 0});
      if (q_m.size() != 0) checkOutput("tx_data", {8'b0, tx_data}, {8'b0, q_m[0]});
    end
    chk_din = model_ok || r;
    exp_din = 16'h0000;
    if (!r) begin
      if (a < 16'h1000) begin
        if (ram_known[a[11:0]]) exp_din = ram_m[a[11:0]];
        else chk_din = 0;
      end else if (a == 16'hFF01) begin
        exp_din = {12'b0, ovf_m, q_m.size() != 0, q_m.size() == 0, q_m.size() == 4};
      end else if (a == 16'hFF02) begin
        exp_din = cnt_m;
      end
    end
    if (w && a < 16'h1000) begin
      ram_m[a[11:0]]     = d;
      ram_known[a[11:0]] = 1;
    end
    if (r) begin
      q_m.delete();
      ovf_m    = 0;
      cnt_m    = 16'h0000;
      model_ok = 1;
    end else begin
      pop_now = (q_m.size() != 0) && rdy;
      if (pop_now) void'(q_m.pop_front());
      if (w && a == 16'hFF00) begin
        if (q_m.size() < 4) q_m.push_back(d[7:0]);
        else ovf_m = 1;
      end
      if (w && a == 16'hFF01 && d[3]) ovf_m = 0;
      if (w && a == 16'hFF02) cnt_m = d;
      else cnt_m = cnt_m + 16'h0001;
    end
    @(posedge clock);
    #1;
    last_din = dmem_din;
    if (chk_din) checkOutput("dmem_din", dmem_din, exp_din);
  endtask

  logic [15:0] addr_pool [10];

  initial begin
    checks   = 0;
    errors   = 0;
    model_ok = 0;
    ovf_m    = 0;
    cnt_m    = 16'h0000;
    for (int i = 0; i < 4096; i++) ram_known[i] = 0;
    rst = 1'b1; dmem_addr = 16'h0; dmem_dout = 16'h0; dmem_we = 1'b0; tx_ready = 1'b0;

    applyStimulus(1, 16'h0000, 16'h0000, 0, 0);
    applyStimulus(1, 16'h0000, 16'h0000, 0, 0);
    checkOutput("rst_din", last_din, 16'h0000);
    checkOutput("rst_tx_valid", {15'b0, tx_valid}, 16'h0000);
    checkOutput("rst_tx_data", {8'b0, tx_data}, 16'h0000);

    // RAM basic loads/stores
    applyStimulus(0, 16'h0010, 16'h1234, 1, 0);
    applyStimulus(0, 16'h0FFF, 16'hBEEF, 1, 0);
    applyStimulus(0, 16'h0010, 16'h0000, 0, 0);
    checkOutput("ram_load_0010", last_din, 16'h1234);
    applyStimulus(0, 16'h0FFF, 16'h0000, 0, 0);
    checkOutput("ram_load_0FFF", last_din, 16'hBEEF);
    applyStimulus(0, 16'h2000, 16'h0000, 0, 0);
    checkOutput("unmapped_2000", last_din, 16'h0000);

    // Read-first collision
    applyStimulus(0, 16'h0010, 16'h5555, 1, 0);
    checkOutput("read_first_old", last_din, 16'h1234);
    applyStimulus(0, 16'h0010, 16'h0000, 0, 0);
    checkOutput("read_first_new", last_din, 16'h5555);

    // FIFO overflow and drain
    for (int i = 0; i < 5; i++) applyStimulus(0, 16'hFF00, 16'h0041 + 16'(i), 1, 0);
    applyStimulus(0, 16'hFF01, 16'h0000, 0, 0);
    checkOutput("status_full_ovf", last_din, 16'h000D);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_byte", {8'b0, tx_data}, 16'h0041 + 16'(i));
      applyStimulus(0, 16'h2000, 16'h0000, 0, 1);
    end
    applyStimulus(0, 16'hFF01, 16'h0000, 0, 1);
    checkOutput("status_drained", last_din, 16'h000A);
    applyStimulus(0, 16'hFF01, 16'h0008, 1, 1);
    applyStimulus(0, 16'hFF01, 16'h0000, 0, 1);
    checkOutput("status_ovf_clr", last_din, 16'h0002);

    // Push into full FIFO while popping
    for (int i = 0; i < 4; i++) applyStimulus(0, 16'hFF00, 16'h0041 + 16'(i), 1, 0);
    applyStimulus(0, 16'hFF00, 16'h0046, 1, 1);
    begin
      logic [7:0] exp_seq [4];
      exp_seq[0] = 8'h42; exp_seq[1] = 8'h43; exp_seq[2] = 8'h44; exp_seq[3] = 8'h46;
      for (int i = 0; i < 4; i++) begin
        checkOutput("full_pushpop_byte", {8'b0, tx_data}, {8'b0, exp_seq[i]});
        applyStimulus(0, 16'h2000, 16'h0000, 0, 1);
      end
    end
    applyStimulus(0, 16'hFF01, 16'h0000, 0, 1);
    checkOutput("status_no_ovf", last_din, 16'h0002);

    // Cycle counter wrap
    applyStimulus(0, 16'hFF02, 16'hFFFE, 1, 0);
    applyStimulus(0, 16'hFF02, 16'h0000, 0, 0);
    checkOutput("cycle_fffe", last_din, 16'hFFFE);
    applyStimulus(0, 16'hFF02, 16'h0000, 0, 0);
    checkOutput("cycle_ffff", last_din, 16'hFFFF);
    applyStimulus(0, 16'hFF02, 16'h0000, 0, 0);
    checkOutput("cycle_wrap", last_din, 16'h0000);

    // Reset mid-transfer with concurrent RAM store
    for (int i = 0; i < 3; i++) applyStimulus(0, 16'hFF00, 16'h0061 + 16'(i), 1, 0);
    applyStimulus(1, 16'h0020, 16'hCAFE, 1, 0);
    checkOutput("midrst_tx_valid", {15'b0, tx_valid}, 16'h0000);
    applyStimulus(0, 16'hFF02, 16'h0000, 0, 0);
    checkOutput("midrst_cycle", last_din, 16'h0000);
    applyStimulus(0, 16'hFF01, 16'h0000, 0, 0);
    checkOutput("midrst_status", last_din, 16'h0002);
    applyStimulus(0, 16'h0010, 16'h0000, 0, 0);
    checkOutput("midrst_ram_0010", last_din, 16'h5555);
    applyStimulus(0, 16'h0020, 16'h0000, 0, 0);
    checkOutput("midrst_ram_0020", last_din, 16'hCAFE);

    // Random traffic against the model
    addr_pool[0] = 16'h0010; addr_pool[1] = 16'h0011; addr_pool[2] = 16'h0012;
    addr_pool[3] = 16'h0FFF; addr_pool[4] = 16'hFF00; addr_pool[5] = 16'hFF01;
    addr_pool[6] = 16'hFF02; addr_pool[7] = 16'hFF03; addr_pool[8] = 16'h1000;
    addr_pool[9] = 16'hFF00;
    for (int n = 0; n < 600; n++) begin
      logic [15:0] ra;
      logic [15:0] rd;
      ra = addr_pool[$urandom_range(0, 9)];
      rd = 16'($urandom);
      applyStimulus(($urandom_range(0, 99) == 0), ra, rd,
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
